// File: rtl/lstm_acc_pkg.sv
// Shared types and AXI constants for the skewed matrix loader.
package lstm_acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_READY,
    ST_STREAM
  } state_t;

  typedef enum logic {
    MODE_ROW = 1'b0,
    MODE_COL = 1'b1
  } mode_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_skew_matrix_loader_if.sv
// AXI read-address / read-data channel bundle used by the matrix loader.
interface axi_skew_matrix_loader_if #(
  parameter int ADDR_W = 12,
  parameter int AXI_DW = 32
);

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic              arlock;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [AXI_DW-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rlast;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arcache, arlock, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid, rlast,
    output rready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arcache, arlock, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_skew_matrix_loader_skew_mux.sv
// Combinational skew mux: selects one anti-diagonal of the matrix onto N lanes.
module matrix_skew_mux
  import lstm_acc_pkg::*;
#(
  parameter int N      = 8,
  parameter int ELEM_W = 8,
  parameter int BEAT_W = 4
) (
  input  logic [N*N*ELEM_W-1:0] mat_flat,
  input  logic [BEAT_W-1:0]     beat,
  input  mode_t                 mode,
  output logic [N*ELEM_W-1:0]   lanes
);

  // Lane i carries row i (row-skew) or column i (column-skew) of anti-diagonal `beat`
  always_comb begin
    lanes = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(beat) >= i && (32'(beat) - i) < N) begin
        if (mode == MODE_ROW)
          lanes[i*ELEM_W +: ELEM_W] = mat_flat[(i*N + (32'(beat) - i))*ELEM_W +: ELEM_W];
        else
          lanes[i*ELEM_W +: ELEM_W] = mat_flat[((32'(beat) - i)*N + i)*ELEM_W +: ELEM_W];
      end
    end
  end

endmodule

// File: rtl/axi_skew_matrix_loader.sv
// Loads an N x N matrix over one AXI read burst, then streams it out skewed.
module axi_skew_matrix_loader
  import lstm_acc_pkg::*;
#(
  parameter int N      = 8,
  parameter int ELEM_W = 8,
  parameter int AXI_DW = 32,
  parameter int ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    abort,
  output logic [N*ELEM_W-1:0]     out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(2*N)-1:0]  out_beat,
  output logic                    out_last,
  output logic                    loaded,
  output logic                    busy,
  output logic                    err,
  axi_skew_matrix_loader_if.master m_axi
);

  localparam int BEAT_W = $clog2(2*N);
  localparam int MAT_W  = N*N*ELEM_W;
  localparam int WORDS  = MAT_W / AXI_DW;
  localparam int EPW    = AXI_DW / ELEM_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2*N-2);
  localparam logic [8:0]        WORDS_CNT = 9'(WORDS);
  localparam logic [8:0]        LAST_WORD = 9'(WORDS-1);

  if ((MAT_W % AXI_DW) != 0 || WORDS < 1 || WORDS > 256 ||
      (AXI_DW % ELEM_W) != 0 || AXI_DW < 8 || N < 2 || N > 16) begin : g_bad_cfg
    $error("axi_skew_matrix_loader: illegal N/ELEM_W/AXI_DW combination");
  end

  state_t              state_q, state_d;
  mode_t               mode_q, mux_mode;
  logic [ADDR_W-1:0]   addr_q;
  logic [8:0]          word_cnt;
  logic [MAT_W-1:0]    mat;
  logic [BEAT_W-1:0]   mux_beat;
  logic [N*ELEM_W-1:0] lane_next;
  logic                load_go, start_go;
  logic                beat_fire, beat_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; abort has priority in READY and STREAM
  always_comb begin
    state_d  = state_q;
    load_go  = 1'b0;
    start_go = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          load_go = 1'b1;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (m_axi.arready) state_d = ST_R;
      end
      ST_R: begin
        if (m_axi.rvalid && m_axi.rlast) state_d = ST_READY;
      end
      ST_READY: begin
        if (abort) begin
          state_d = ST_READY;
        end else if (load_start) begin
          load_go = 1'b1;
          state_d = ST_AR;
        end else if (start && loaded) begin
          start_go = 1'b1;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (abort) state_d = ST_READY;
        else if (out_valid && out_ready && out_last) state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs: AXI request channel, rready, busy and the skew mux select
  always_comb begin
    m_axi.araddr  = '0;
    m_axi.arlen   = '0;
    m_axi.arsize  = '0;
    m_axi.arburst = '0;
    m_axi.arcache = '0;
    m_axi.arlock  = 1'b0;
    m_axi.arprot  = '0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    busy          = 1'b0;
    mux_beat      = '0;
    mux_mode      = mode_t'(mode);
    case (state_q)
      ST_AR: begin
        m_axi.araddr  = addr_q;
        m_axi.arlen   = 8'(WORDS-1);
        m_axi.arsize  = 3'($clog2(AXI_DW/8));
        m_axi.arburst = AXI_BURST_INCR;
        m_axi.arvalid = 1'b1;
        busy          = 1'b1;
      end
      ST_R: begin
        m_axi.rready = 1'b1;
        busy         = 1'b1;
      end
      ST_STREAM: begin
        busy     = 1'b1;
        mux_beat = out_beat + 1'b1;
        mux_mode = mode_q;
      end
      default: ;
    endcase
  end

  // Per-beat read decode: accepted beat and any protocol/response error on it
  always_comb begin
    beat_fire = (state_q == ST_R) && m_axi.rvalid;
    beat_err  = (m_axi.rresp != AXI_RESP_OKAY) ||
                (m_axi.rlast != (word_cnt == LAST_WORD));
  end

  // Burst bookkeeping: base address, word counter, sticky error and loaded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
      loaded   <= 1'b0;
    end else if (load_go) begin
      addr_q   <= cfg_base_addr;
      word_cnt <= '0;
      err      <= 1'b0;
      loaded   <= 1'b0;
    end else if (beat_fire) begin
      if (word_cnt != WORDS_CNT) word_cnt <= word_cnt + 1'b1;
      if (beat_err) err <= 1'b1;
      if (m_axi.rlast) loaded <= !(err || beat_err);
    end
  end

  // Matrix storage, written from each accepted beat; not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (beat_fire && word_cnt < WORDS_CNT) begin
      for (int unsigned b = 0; b < EPW; b++)
        mat[(32'(word_cnt)*EPW + b)*ELEM_W +: ELEM_W] <= m_axi.rdata[b*ELEM_W +: ELEM_W];
    end
  end

  matrix_skew_mux #(
    .N      (N),
    .ELEM_W (ELEM_W),
    .BEAT_W (BEAT_W)
  ) u_skew_mux (
    .mat_flat (mat),
    .beat     (mux_beat),
    .mode     (mux_mode),
    .lanes    (lane_next)
  );

  // Registered stream outputs; the mux always presents the beat that loads next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_beat  <= '0;
      out_data  <= '0;
      mode_q    <= MODE_ROW;
    end else if (start_go) begin
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      out_beat  <= '0;
      out_data  <= lane_next;
      mode_q    <= mode_t'(mode);
    end else if (state_q == ST_STREAM) begin
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_beat  <= '0;
      end else if (out_valid && out_ready) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_beat  <= '0;
        end else begin
          out_beat <= mux_beat;
          out_last <= (mux_beat == LAST_BEAT);
          out_data <= lane_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_skew_matrix_loader.sv
// Self-checking bench: random matrices, AXI slave timing and out_ready stalls
// compared against a scatter-style reference of the skewed stream.
module tb_axi_skew_matrix_loader;

  localparam int N      = 8;
  localparam int ELEM_W = 8;
  localparam int AXI_DW = 32;
  localparam int ADDR_W = 12;
  localparam int WORDS  = N*N*ELEM_W/AXI_DW;
  localparam int EPW    = AXI_DW/ELEM_W;
  localparam int NBEATS = 2*N-1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   load_start = 1'b0;
  logic [ADDR_W-1:0]      cfg_base_addr = '0;
  logic                   start = 1'b0;
  logic                   mode = 1'b0;
  logic                   abort = 1'b0;
  logic                   out_ready = 1'b0;
  logic [N*ELEM_W-1:0]    out_data;
  logic                   out_valid, out_last, loaded, busy, err;
  logic [$clog2(2*N)-1:0] out_beat;

  axi_skew_matrix_loader_if #(.ADDR_W(ADDR_W), .AXI_DW(AXI_DW)) axi ();

  axi_skew_matrix_loader #(
    .N(N), .ELEM_W(ELEM_W), .AXI_DW(AXI_DW), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .cfg_base_addr(cfg_base_addr),
    .start(start), .mode(mode), .abort(abort), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_beat(out_beat),
    .out_last(out_last), .loaded(loaded), .busy(busy), .err(err), .m_axi(axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [ELEM_W-1:0]   ref_m [N][N];
  logic [N*ELEM_W-1:0] exp_beats [NBEATS];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: element M[r][c] lands on beat r+c, in lane r (row-skew) or lane c (column-skew)
  task automatic build_expected(input logic m);
    int lane;
    for (int k = 0; k < NBEATS; k++) exp_beats[k] = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        lane = (m == 1'b0) ? r : c;
        exp_beats[r+c][lane*ELEM_W +: ELEM_W] = ref_m[r][c];
      end
  endtask

  function automatic logic [AXI_DW-1:0] pack_word(input int w);
    logic [AXI_DW-1:0] v;
    int e;
    v = '0;
    for (int b = 0; b < EPW; b++) begin
      e = w*EPW + b;
      v[b*ELEM_W +: ELEM_W] = ref_m[e/N][e%N];
    end
    return v;
  endfunction

  task automatic randomize_matrix();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) ref_m[r][c] = ELEM_W'($urandom);
  endtask

  // Issue a load and play the AXI slave; rlast on word rlast_at, SLVERR on bad_word,
  // and an asynchronous reset in place of beat reset_at when reset_at >= 0
  task automatic axi_load(input logic [ADDR_W-1:0] base, input int bad_word,
                          input int rlast_at, input int reset_at);
    int gap;
    @(negedge clk);
    load_start = 1'b1;
    cfg_base_addr = base;
    @(negedge clk);
    load_start = 1'b0;
    cfg_base_addr = ADDR_W'($urandom);
    check_eq("arvalid", axi.arvalid, 1);
    check_eq("araddr", axi.araddr, base);
    check_eq("arlen", axi.arlen, WORDS-1);
    check_eq("arsize", axi.arsize, $clog2(AXI_DW/8));
    check_eq("arburst", axi.arburst, 2'b01);
    check_eq("ar_misc", {axi.arcache, axi.arlock, axi.arprot}, 0);
    check_eq("busy_ar", busy, 1);
    check_eq("loaded_clr", loaded, 0);
    check_eq("err_clr", err, 0);
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check_eq("arvalid_hold", axi.arvalid, 1);
    end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    check_eq("arvalid_drop", axi.arvalid, 0);
    check_eq("rready_r", axi.rready, 1);
    for (int w = 0; w <= rlast_at; w++) begin
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) @(negedge clk);
      if (w == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_arvalid", axi.arvalid, 0);
        check_eq("rst_rready", axi.rready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_loaded", loaded, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      axi.rvalid = 1'b1;
      axi.rdata  = pack_word(w);
      axi.rresp  = (w == bad_word) ? 2'b10 : 2'b00;
      axi.rlast  = (w == rlast_at);
      check_eq("rready_beat", axi.rready, 1);
      @(negedge clk);
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
    end
    check_eq("rready_done", axi.rready, 0);
    check_eq("busy_done", busy, 0);
  endtask

  // stall: 0 = ready held high, 1 = random, 2 = stall pattern 1,0,0,1 around beat 3
  task automatic run_stream(input logic m, input int abort_at, input int ls_at, input int stall);
    int  k;
    int  cyc;
    int  stall_cnt;
    bit  done;
    bit  rdy;
    k = 0; cyc = 0; stall_cnt = 0; done = 1'b0;
    build_expected(m);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom);
    check_eq("first_valid", out_valid, 1);
    while (!done && cyc < 200) begin
      if (!out_valid) begin
        check_eq("valid_gap", out_valid, 1);
        break;
      end
      check_eq($sformatf("data_b%0d", k), out_data, exp_beats[k]);
      check_eq("beat", out_beat, k);
      check_eq("last", out_last, k == NBEATS-1);
      if (k == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
        out_ready = 1'($urandom);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_beat", out_beat, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_loaded", loaded, 1);
        return;
      end
      case (stall)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom);
        default: begin
          if (k == 3) begin
            rdy = (stall_cnt >= 2);
            stall_cnt++;
          end else rdy = 1'b1;
        end
      endcase
      out_ready = rdy;
      load_start = (k == ls_at);
      @(negedge clk);
      cyc++;
      if (load_start) check_eq("ls_ignored", axi.arvalid, 0);
      load_start = 1'b0;
      if (rdy) begin
        if (k == NBEATS-1) done = 1'b1;
        else k++;
      end
    end
    if (!done) check_eq("stream_done", done, 1);
    out_ready = 1'b0;
    check_eq("end_valid", out_valid, 0);
    check_eq("end_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_arvalid0", axi.arvalid, 0);
    check_eq("rst_rready0", axi.rready, 0);
    check_eq("rst_araddr0", axi.araddr, 0);
    check_eq("rst_arlen0", axi.arlen, 0);
    check_eq("rst_valid0", out_valid, 0);
    check_eq("rst_last0", out_last, 0);
    check_eq("rst_beat0", out_beat, 0);
    check_eq("rst_data0", out_data, 0);
    check_eq("rst_flags0", {loaded, busy, err}, 0);
    rst_n = 1'b1;

    // start with nothing loaded
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("start_unloaded", out_valid, 0);
    check_eq("start_unloaded_busy", busy, 0);

    // ramp matrix M[r][c] = 8r+c from 0x100
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) ref_m[r][c] = ELEM_W'(8*r + c);
    axi_load(12'h100, -1, WORDS-1, -1);
    check_eq("loaded_ok", loaded, 1);
    check_eq("err_ok", err, 0);
    run_stream(1'b0, -1, -1, 0);
    run_stream(1'b1, -1, 5, 2);
    run_stream(1'b0, 4, -1, 1);
    run_stream(1'b0, -1, -1, 0);

    // abort and start together in READY
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_eq("abort_start_valid", out_valid, 0);
    check_eq("abort_start_busy", busy, 0);

    // SLVERR on word 5: burst drained, matrix not marked loaded
    randomize_matrix();
    axi_load(ADDR_W'($urandom), 5, WORDS-1, -1);
    check_eq("slverr_err", err, 1);
    check_eq("slverr_loaded", loaded, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("slverr_start_ignored", out_valid, 0);
      @(negedge clk);
    end

    // early rlast
    axi_load(ADDR_W'($urandom), -1, 9, -1);
    check_eq("early_rlast_err", err, 1);
    check_eq("early_rlast_loaded", loaded, 0);

    // good reloads with random data, modes and stalls
    for (int t = 0; t < 3; t++) begin
      randomize_matrix();
      axi_load(ADDR_W'($urandom), -1, WORDS-1, -1);
      check_eq("reload_loaded", loaded, 1);
      check_eq("reload_err", err, 0);
      run_stream(1'($urandom), -1, -1, 1);
      run_stream(1'($urandom), $urandom_range(0, NBEATS-1), -1, 1);
      run_stream(1'($urandom), -1, -1, 1);
    end

    // reset in the middle of the read burst, then recover
    axi_load(ADDR_W'($urandom), -1, WORDS-1, 3);
    check_eq("post_rst_valid", out_valid, 0);
    randomize_matrix();
    axi_load(ADDR_W'($urandom), -1, WORDS-1, -1);
    check_eq("post_rst_loaded", loaded, 1);
    run_stream(1'b1, -1, -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_skew_matrix_loader.md
AXI_SKEW_MATRIX_LOADER -- requirements
Module: axi_skew_matrix_loader

Interface
REQ-001 Parameter N, default 8: matrix dimension (N x N), legal 2..16.
REQ-002 Parameter ELEM_W, default 8: element width in bits.
REQ-003 Parameter AXI_DW, default 32: AXI read data width; N*N*ELEM_W/AXI_DW SHALL be an integer in 1..256 (elaboration-time check).
REQ-004 Parameter ADDR_W, default 12: AXI address width.
REQ-005 Ports SHALL be:
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- load_start in 1: pulse, begin matrix load.
- cfg_base_addr in ADDR_W: burst start address, sampled on an accepted load_start.
- start in 1: pulse, begin one skewed stream pass.
- mode in 1: 0 = row-skew, 1 = column-skew; sampled on an accepted start.
- abort in 1: synchronous pass cancel.
- out_data out N*ELEM_W: skewed lanes, lane i at [i*ELEM_W +: ELEM_W].
- out_valid out 1; out_ready in 1: output handshake.
- out_beat out clog2(2N): beat index of the current out_data.
- out_last out 1: final beat of a pass.
- loaded out 1: matrix resident.
- busy out 1: not IDLE and not READY.
- err out 1: sticky load error.
- m_axi_ar* out: araddr ADDR_W, arlen 8, arsize 3, arburst 2, arcache 4, arlock 1, arprot 3, arvalid 1.
- m_axi_arready in 1.
- m_axi_rdata in AXI_DW; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rlast in 1.
- m_axi_rready out 1.

Function
REQ-006 States SHALL be IDLE, AR, R, READY, STREAM.
REQ-007 IDLE/READY + load_start -> AR: araddr=cfg_base_addr, arlen=WORDS-1, arsize=log2(AXI_DW/8), arburst=INCR, arcache/arlock/arprot=0, arvalid=1; loaded cleared, err cleared, word counter cleared.
REQ-008 AR: arvalid held high until arvalid&&arready, then deasserted next cycle -> R with rready=1.
REQ-009 R: each rvalid&&rready beat w SHALL write element e=w*(AXI_DW/ELEM_W)+b from rdata[b*ELEM_W +: ELEM_W] to row e/N, column e%N.
REQ-010 R: rresp!=0 on any beat, rlast before beat WORDS-1, or beat WORDS-1 without rlast SHALL set err; the burst is still drained to rlast.
REQ-011 rlast accepted -> READY, rready=0; loaded=1 only if err=0.
REQ-012 READY + start && loaded -> STREAM at beat 0; start without loaded, or in any other state, SHALL be ignored.
REQ-013 STREAM beat k (0..2N-2), mode 0: lane i = M[i][k-i] if 0<=k-i<N, else 0; mode 1: lane j = M[k-j][j] if 0<=k-j<N, else 0.
REQ-014 out_data, out_beat, out_last and out_valid SHALL be registered; first out_valid the cycle after the accepted start.
REQ-015 out_data, out_beat and out_last SHALL hold stable while out_valid&&!out_ready; the beat advances only on handshake, so 2N-1 beats take 2N-1 cycles with out_ready held high.
REQ-016 out_last=1 on beat 2N-2; its handshake -> READY, out_valid=0 next cycle.
REQ-017 abort SHALL force READY with out_valid=0 next cycle, clear the beat counter, and preserve the matrix and loaded; abort in AR/R SHALL be ignored.
REQ-018 load_start during AR, R or STREAM SHALL be ignored; abort and start in the same cycle: abort wins.

Reset
REQ-019 rst_n low SHALL asynchronously force: IDLE; all m_axi_* outputs 0; out_valid, out_last and out_beat 0; out_data 0; loaded, busy and err 0.
REQ-020 Matrix storage SHALL NOT be reset; reset mid-burst SHALL abandon the transaction, and the interconnect is reset with it.

Structure
REQ-021 Shared package lstm_acc_pkg SHALL hold the state enum, the mode enum, and the constants AXI_BURST_INCR=2'b01 and AXI_RESP_OKAY=2'b00.
REQ-022 The combinational skew mux SHALL be sub-module matrix_skew_mux (inputs: flat matrix, beat, mode; output: lanes).

Verification
REQ-023 N=8, M[r][c]=8*r+c loaded from 0x100, mode 0, out_ready=1 -> arlen=15, arsize=2; beat 0 lanes {0,...,0,0x00}; beat 7 lane i=0x07+7*i; beat 14 lane 7=0x3F, other lanes 0; out_last on beat 14.
REQ-024 Same matrix, mode 1 -> beat 1 lane0=0x08, lane1=0x01, lanes 2..7=0.
REQ-025 out_ready toggled 1,0,0,1 during beat 3 -> out_data and out_beat=3 held stable across the stall; no beat skipped or duplicated.
REQ-026 rresp=2'b10 on word 5 -> all 16 words still accepted; err=1; loaded=0; a following start is ignored.
REQ-027 abort at beat 4 then start -> stream restarts at beat 0 with identical data; rst_n pulse during R -> arvalid=0, rready=0 and IDLE immediately.
